// File: rtl/bounce_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module      : bounce_sprite_engine
// Description : Multi-ball bouncing sprite engine for a racing-the-beam VGA
//               pipeline. Holds NUM_BALLS circular sprites, advances them one
//               ball per cycle after each frame_start, and hit-tests every
//               pixel against all balls to produce a registered 6-bit colour.
//               Optional feature macro: BALL_GRAVITY_EN (adds per-frame
//               downward acceleration to vy, saturating at +7).
// Revision    : 1.0 - initial release
// ============================================================================
module bounce_sprite_engine #(
  parameter int NUM_BALLS = 4,
  parameter int RADIUS    = 16,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       enable,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  output logic [5:0] rgb,
  output logic       hit,
  output logic       busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                 IDX_W    = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_BALLS - 1);
  // Lowest legal centre coordinate on either axis (ball touches the edge).
  localparam logic signed [11:0] POS_MIN  = 12'(RADIUS);
  // Highest legal centre coordinates.
  localparam logic signed [11:0] X_MAX    = 12'(SCREEN_W - 1 - RADIUS);
  localparam logic signed [11:0] Y_MAX    = 12'(SCREEN_H - 1 - RADIUS);
  localparam logic [10:0]        R_BOX    = 11'(RADIUS);
  localparam logic [21:0]        R_SQ     = 22'(RADIUS * RADIUS);

  // Palette entries {R[1:0],G[1:0],B[1:0]}.
  localparam logic [5:0] COL_ORANGE  = 6'b11_10_00;
  localparam logic [5:0] COL_CYAN    = 6'b00_11_11;
  localparam logic [5:0] COL_MAGENTA = 6'b11_00_11;
  localparam logic [5:0] COL_GREEN   = 6'b00_11_00;

  // --------------------------------------------------------------------------
  // Update state machine and ball state
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;

  // Centre coordinates and two's-complement velocities for every ball.
  logic [NUM_BALLS-1:0][9:0] ball_x;
  logic [NUM_BALLS-1:0][9:0] ball_y;
  logic [NUM_BALLS-1:0][3:0] ball_vx;
  logic [NUM_BALLS-1:0][3:0] ball_vy;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  // Magnitude of a 4-bit signed velocity; -8 has no positive twin, so it
  // saturates to +7.
  function automatic logic [3:0] abs_vel(input logic [3:0] v);
    if (v == 4'b1000) begin
      return 4'd7;
    end else if (v[3]) begin
      return 4'(-v);
    end else begin
      return v;
    end
  endfunction

  // One axis of motion with wall reflection. Returns {new_pos[9:0], new_vel[3:0]}.
  // The sum is done in 12-bit signed so that moving left past zero is seen as
  // negative rather than wrapping to a large coordinate.
  function automatic logic [13:0] axis_step(input logic [9:0]         pos,
                                            input logic [3:0]         vel,
                                            input logic signed [11:0] hi);
    logic signed [11:0] np;
    logic [3:0]         mag;
    np  = $signed({2'b00, pos}) + $signed({{8{vel[3]}}, vel});
    mag = abs_vel(vel);
    if (np < POS_MIN) begin
      return {POS_MIN[9:0], mag};
    end else if (np > hi) begin
      return {hi[9:0], 4'(-mag)};
    end else begin
      return {np[9:0], vel};
    end
  endfunction

  // Colour of ball i; the palette repeats every four balls.
  function automatic logic [5:0] palette(input int i);
    case (i % 4)
      0:       return COL_ORANGE;
      1:       return COL_CYAN;
      2:       return COL_MAGENTA;
      default: return COL_GREEN;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Next state of the ball currently addressed by idx
  // --------------------------------------------------------------------------
  logic [9:0]  cur_x;
  logic [9:0]  cur_y;
  logic [3:0]  cur_vx;
  logic [3:0]  cur_vy;
  logic [3:0]  vy_in;
  logic [13:0] step_x;
  logic [13:0] step_y;

  // Compute the reflected position/velocity pair for the selected ball.
  always_comb begin
    cur_x  = ball_x[idx];
    cur_y  = ball_y[idx];
    cur_vx = ball_vx[idx];
    cur_vy = ball_vy[idx];
`ifdef BALL_GRAVITY_EN
    // Gravity pulls vy one step downward per frame, capped at +7.
    vy_in  = (cur_vy == 4'd7) ? 4'd7 : 4'(cur_vy + 4'd1);
`else
    vy_in  = cur_vy;
`endif
    step_x = axis_step(cur_x, cur_vx, X_MAX);
    step_y = axis_step(cur_y, vy_in, Y_MAX);
  end

  // Update FSM: one ball written per UPDATE cycle; frame_start is only
  // accepted in IDLE, so pulses during a sweep are dropped, not queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        ball_x[i]  <= 10'(80 + 64 * i);
        ball_y[i]  <= 10'(60 + 40 * i);
        ball_vx[i] <= (i % 2 == 0) ? 4'd2 : 4'b1101;
        ball_vy[i] <= 4'(1 + i % 3);
      end
    end else begin
      case (state)
        IDLE: begin
          if (frame_start && enable) begin
            state <= UPDATE;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        UPDATE: begin
          // enable is deliberately not consulted here: a started sweep
          // always completes so all balls stay on the same frame count.
          ball_x[idx]  <= step_x[13:4];
          ball_vx[idx] <= step_x[3:0];
          ball_y[idx]  <= step_y[13:4];
          ball_vy[idx] <= step_y[3:0];
          if (idx == LAST_IDX) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Per-ball hit test against the live beam position
  // --------------------------------------------------------------------------
  logic [NUM_BALLS-1:0] ball_hit;

  for (genvar gi = 0; gi < NUM_BALLS; gi++) begin : g_hit
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic [10:0]        adx;
    logic [10:0]        ady;
    logic [11:0]        dist_sq;

    assign dx  = $signed({1'b0, hpos}) - $signed({1'b0, ball_x[gi]});
    assign dy  = $signed({1'b0, vpos}) - $signed({1'b0, ball_y[gi]});
    assign adx = dx[10] ? $unsigned(-dx) : $unsigned(dx);
    assign ady = dy[10] ? $unsigned(-dy) : $unsigned(dy);
    // The bounding box limits |dx|,|dy| to at most 31, so the squares only
    // need the low six bits; outside the box the product is irrelevant.
    assign dist_sq = 12'(adx[5:0]) * 12'(adx[5:0]) + 12'(ady[5:0]) * 12'(ady[5:0]);
    assign ball_hit[gi] = (adx <= R_BOX) && (ady <= R_BOX) && ({10'd0, dist_sq} <= R_SQ);
  end : g_hit

  // --------------------------------------------------------------------------
  // Priority select and output register
  // --------------------------------------------------------------------------
  logic [5:0] pix_colour;
  logic       pix_hit;

  // Scan from highest to lowest index so the lowest-index hit wins.
  always_comb begin
    pix_colour = 6'd0;
    pix_hit    = 1'b0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (ball_hit[i]) begin
        pix_colour = palette(i);
        pix_hit    = 1'b1;
      end
    end
  end

  // Register the pixel colour; blanking and background are black with no hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb <= 6'd0;
      hit <= 1'b0;
    end else if (display_on && pix_hit) begin
      rgb <= pix_colour;
      hit <= 1'b1;
    end else begin
      rgb <= 6'd0;
      hit <= 1'b0;
    end
  end

endmodule : bounce_sprite_engine
`default_nettype wire

// File: tb/tb_bounce_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_bounce_sprite_engine
// Description : Directed self-checking bench for bounce_sprite_engine. Covers
//               reset, rendering/hit boundaries, palette priority, update
//               timing, ignored frame_start pulses, wall bounce and reset in
//               the middle of an update. Gravity build (BALL_GRAVITY_EN)
//               swaps the motion section for a vy saturation sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bounce_sprite_engine;

  logic       clk;
  logic       reset;
  logic       frame_start;
  logic       enable;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic [5:0] rgb;
  logic       hit;
  logic       busy;

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] ORANGE  = 6'b11_10_00;
  localparam logic [5:0] CYAN    = 6'b00_11_11;
  localparam logic [5:0] MAGENTA = 6'b11_00_11;
  localparam logic [5:0] GREEN   = 6'b00_11_00;

  bounce_sprite_engine #(
    .NUM_BALLS(4),
    .RADIUS   (16),
    .SCREEN_W (640),
    .SCREEN_H (480)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .enable     (enable),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .rgb        (rgb),
    .hit        (hit),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a beam position at a negedge; the result is registered one cycle later.
  task automatic pix(input string tag, input int h, input int v, input logic on,
                     input logic [5:0] exp_rgb, input logic exp_hit);
    hpos       = 10'(h);
    vpos       = 10'(v);
    display_on = on;
    @(negedge clk);
    check({tag, "_rgb"}, 32'(rgb), 32'(exp_rgb));
    check({tag, "_hit"}, 32'(hit), 32'(exp_hit));
  endtask

  // One frame_start pulse, then wait (bounded) for the sweep to finish.
  task automatic do_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int c = 0; c < 16 && busy; c++) @(negedge clk);
    check("frame_end", 32'(busy), 32'd0);
  endtask

  task automatic check_ball(input string tag, input int i, input int ex, input int ey);
    check({tag, "_x"}, 32'(dut.ball_x[i]), 32'(ex));
    check({tag, "_y"}, 32'(dut.ball_y[i]), 32'(ey));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    enable      = 1'b1;
    hpos        = 10'd0;
    vpos        = 10'd0;
    display_on  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Put a lit pixel in the output register, then reset asynchronously mid-line.
    pix("pre_reset", 80, 60, 1'b1, ORANGE, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_ball("rst_b0", 0, 80, 60);
    check("rst_b0_vx", 32'(dut.ball_vx[0]), 32'h2);
    check("rst_b0_vy", 32'(dut.ball_vy[0]), 32'h1);
    check_ball("rst_b1", 1, 144, 100);
    check("rst_b1_vx", 32'(dut.ball_vx[1]), 32'hD);
    check("rst_b1_vy", 32'(dut.ball_vy[1]), 32'h2);
    @(negedge clk);
    reset = 1'b0;

    // Rendering around ball 0 (80,60) and ball 1 (144,100), radius 16.
    pix("centre0",   80,  60, 1'b1, ORANGE, 1'b1);
    pix("right16",   96,  60, 1'b1, ORANGE, 1'b1);
    pix("right17",   97,  60, 1'b1, 6'd0,   1'b0);
    pix("top16",     80,  44, 1'b1, ORANGE, 1'b1);
    pix("diag11",    91,  71, 1'b1, ORANGE, 1'b1);
    pix("diag12",    92,  72, 1'b1, 6'd0,   1'b0);
    pix("centre1",  144, 100, 1'b1, CYAN,   1'b1);
    pix("blank0",    80,  60, 1'b0, 6'd0,   1'b0);
    pix("bg",       300, 300, 1'b1, 6'd0,   1'b0);

`ifdef BALL_GRAVITY_EN
    // vy0 starts at +1 and gains 1 per frame before the y step.
    repeat (5) do_frame();
    check("grav_vy5", 32'(dut.ball_vy[0]), 32'h6);
    check("grav_y5", 32'(dut.ball_y[0]), 32'd80);
    do_frame();
    check("grav_vy6", 32'(dut.ball_vy[0]), 32'h7);
    check("grav_y6", 32'(dut.ball_y[0]), 32'd87);
    do_frame();
    check("grav_vy7_sat", 32'(dut.ball_vy[0]), 32'h7);
    check("grav_y7", 32'(dut.ball_y[0]), 32'd94);
    enable      = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("grav_dis_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("grav_dis_y", 32'(dut.ball_y[0]), 32'd94);
    check("grav_dis_vy", 32'(dut.ball_vy[0]), 32'h7);
    enable = 1'b1;
`else
    // Update timing: busy for exactly 4 cycles; a pulse on the final cycle is dropped.
    hpos = 10'd0; vpos = 10'd480; display_on = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_c2", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_c3", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_c4", 32'(busy), 32'd1);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("busy_c5", 32'(busy), 32'd0);
    @(negedge clk);
    check("busy_noqueue", 32'(busy), 32'd0);
    check_ball("upd1_b0", 0, 82, 61);
    check_ball("upd1_b1", 1, 141, 102);

    // frame_start with motion disabled changes nothing.
    enable      = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("dis_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_ball("dis_b0", 0, 82, 61);

    // Frame 2: enable drops right after the sweep starts; it must still finish.
    enable      = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    enable      = 1'b0;
    for (int c = 0; c < 16 && busy; c++) @(negedge clk);
    check("f2_end", 32'(busy), 32'd0);
    check_ball("f2_b3", 3, 266, 182);
    enable = 1'b1;

    // Frames 3..13: balls 2 and 3 overlap at (234,179) / (233,193).
    repeat (11) do_frame();
    check_ball("f13_b0", 0, 106, 73);
    check_ball("f13_b2", 2, 234, 179);
    check_ball("f13_b3", 3, 233, 193);
    pix("overlap23", 233, 186, 1'b1, MAGENTA, 1'b1);
    pix("only3",     233, 200, 1'b1, GREEN,   1'b1);
    pix("ovl_blank", 233, 186, 1'b0, 6'd0,    1'b0);
    display_on = 1'b0;

    // Run ball 0 to x=622 (frame 271), then into the right wall.
    repeat (258) do_frame();
    check("f271_b0_x", 32'(dut.ball_x[0]), 32'd622);
    check("f271_b0_vx", 32'(dut.ball_vx[0]), 32'h2);
    do_frame();
    check_ball("wall_b0", 0, 623, 332);
    check("wall_b0_vx", 32'(dut.ball_vx[0]), 32'hE);
    pix("wall_pix", 623, 332, 1'b1, ORANGE, 1'b1);
    display_on = 1'b0;
    do_frame();
    check("after_wall_x", 32'(dut.ball_x[0]), 32'd621);

    // Reset after ball 0 of a sweep has been written discards everything.
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    check("mid_b0_x", 32'(dut.ball_x[0]), 32'd619);
    check("mid_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check_ball("midrst_b0", 0, 80, 60);
    check("midrst_b0_vx", 32'(dut.ball_vx[0]), 32'h2);
    check_ball("midrst_b3", 3, 272, 180);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bounce_sprite_engine
`default_nettype wire

// File: doc/bounce_sprite_engine.md
# bounce_sprite_engine

Parametrised multi-ball sprite engine for the racing-the-beam VGA pipeline. It holds NUM_BALLS bouncing circular sprites and advances their positions once per frame with a serial update state machine. Each pixel it hit-tests the current beam position against every ball and emits a registered 6-bit colour. It sits between the hvsync generator and the uo_out packing in the top level, which delays hsync/vsync by one cycle to match.

## Interface
- NUM_BALLS, 4: number of balls, 1..8
- RADIUS, 16: radius of every ball in pixels, 4..31
- SCREEN_W, 640: active width in pixels
- SCREEN_H, 480: active height in pixels

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the first blanking line (vpos==SCREEN_H, hpos==0)
- enable  in  1  motion enable; low freezes all balls, rendering continues
- hpos  in  10  beam x
- vpos  in  10  beam y
- display_on  in  1  beam in active area
- rgb  out  6  {R[1:0],G[1:0],B[1:0]}, registered
- hit  out  1  registered; any ball covers the pixel
- busy  out  1  update FSM not IDLE

## Operation
- Per-ball state: x[9:0], y[9:0] (centre), vx[3:0], vy[3:0] (two's complement).
- Reset values for ball i: x=80+64·i, y=60+40·i, vx=+2 for even i and −3 for odd i, vy=+1+(i mod 3). Outputs: rgb=0, hit=0, busy=0.
- FSM states:
  - IDLE → UPDATE on frame_start && enable.
  - UPDATE processes ball idx=0..NUM_BALLS−1, one ball per cycle.
  - UPDATE → IDLE after the last ball is processed.
- Per-ball update, done in 12-bit signed arithmetic:
  - nx = x + vx.
  - If nx < RADIUS: x=RADIUS, vx=+|vx|.
  - Else if nx > SCREEN_W−1−RADIUS: x=SCREEN_W−1−RADIUS, vx=−|vx|.
  - Else x=nx.
  - y and vy follow the same rule, using SCREEN_H for the bounds.
  - |−8| saturates to +7.
- frame_start is ignored while busy or while enable=0. No queuing.
- Hit test for ball i:
  - dx = hpos − x and dy = vpos − y, each 11-bit signed.
  - Bounding-box prefilter: |dx|≤RADIUS and |dy|≤RADIUS.
  - Then dx²+dy² ≤ RADIUS² (22-bit unsigned compare).
- Priority: the lowest-index hit ball wins.
- Palette by i mod 4: 0 orange 11_10_00, 1 cyan 00_11_11, 2 magenta 11_00_11, 3 green 00_11_00.
- Background and blanking (display_on=0) output 00_00_00 with hit=0.
- Rendering reads live ball registers. Because frame_start falls in vertical blanking, no torn frames occur.

## Timing
- rgb and hit appear 1 cycle after the hpos/vpos/display_on they correspond to.
- An update occupies NUM_BALLS cycles:
  - busy rises the cycle after frame_start.
  - busy falls the cycle after the last ball is written.
- A frame_start coincident with the final UPDATE cycle is ignored.
- Reset asserted mid-update: all state returns immediately to reset values and FSM=IDLE. Partial updates are discarded.
- enable falling mid-update does not abort the current update sweep.

## Configuration
- BALL_GRAVITY_EN defined:
  - Before each ball's y update, vy = min(vy+1, +7).
  - A floor bounce sets vy=−|vy|, so balls arc and bounce.
- BALL_GRAVITY_EN undefined:
  - vy changes only by sign flips at the walls.
  - Motion is straight-line with constant speed.

## Test plan
- Reset: assert reset mid-line → rgb=0, hit=0, busy=0. Ball 0 at (80,60) with vx=+2, vy=+1; ball 1 at (144,100).
- Render: beam at (80,60), display_on=1 → next cycle rgb=11_10_00, hit=1. At (97,60): hit=0, because dx=17 > RADIUS.
- Priority: force ball 1 onto ball 0's centre → overlap pixel shows orange. Blanking over the ball gives rgb=0.
- Update: one frame_start pulse → busy high for exactly 4 cycles, then ball 0 at (82,61). Non-gravity build.
- Wall bounce: ball 0 x=622, vx=+2 → after frame_start x=623, vx=−2. Next frame x=621.
- Gravity (BALL_GRAVITY_EN): vy=+6 → +7, then stays +7 (saturated). frame_start with enable=0 → no state change, busy stays 0.
